// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the memory stage, the arbiter and the memory macro.
// The arbiter uses the slave view; the surrounding logic (or a bench) uses the master view.
interface mem_port_arbiter_if;
  // Handshake: ifReq/dReq are levels held with their address/data stable until the
  // matching one-cycle ifDone/dDone pulse; the cycle after done the requester may drop or
  // re-present a request. memEn is a one-cycle strobe with no back-pressure and
  // memRdData is valid exactly MEM_LAT cycles after it.
  logic        ifReq;
  logic [15:0] ifAddr;
  logic        ifDone;
  logic [15:0] ifData;

  logic        dReq;
  logic        dWr;
  logic [15:0] dAddr;
  logic [15:0] dWrData;
  logic        dDone;
  logic [15:0] dRdData;
  logic        dErr;

  logic        haltReq;
  logic        halted;

  logic        memEn;
  logic        memWr;
  logic [15:0] memAddr;
  logic [15:0] memWrData;
  logic [15:0] memRdData;

  modport slave (
    input  ifReq, ifAddr, dReq, dWr, dAddr, dWrData, haltReq, memRdData,
    output ifDone, ifData, dDone, dRdData, dErr, halted,
           memEn, memWr, memAddr, memWrData
  );

  modport master (
    output ifReq, ifAddr, dReq, dWr, dAddr, dWrData, haltReq, memRdData,
    input  ifDone, ifData, dDone, dRdData, dErr, halted,
           memEn, memWr, memAddr, memWrData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data has priority over fetch, with a starvation guard,
// and every access walks IDLE -> ISSUE -> WAIT -> DONE. HALT parks the arbiter for good.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_port_arbiter_if.slave       bus,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam bit         STARVE_ON  = (STARVE_MAX != 0);

  state_t      state, state_nx;
  logic [3:0]  lat_cnt, lat_nx;
  logic [3:0]  starve_cnt, starve_nx;
  logic        halt_pend, halt_pend_nx;
  logic        owner_d, owner_d_nx;
  logic        err_q, err_nx;
  logic        wr_q, wr_nx;
  logic [15:0] addr_q, addr_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic [15:0] if_data_q;
  logic [15:0] d_rd_data_q;
  logic        grant_if, grant_d;
  logic        capture;
  logic        mem_en;
  logic        in_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      halt_pend   <= 1'b0;
      owner_d     <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_data_q   <= '0;
      d_rd_data_q <= '0;
    end else begin
      state      <= state_nx;
      lat_cnt    <= lat_nx;
      starve_cnt <= starve_nx;
      halt_pend  <= halt_pend_nx;
      owner_d    <= owner_d_nx;
      err_q      <= err_nx;
      wr_q       <= wr_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      if (capture && !owner_d) begin
        if_data_q <= bus.memRdData;
      end
      if (capture && owner_d && !wr_q) begin
        d_rd_data_q <= bus.memRdData;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    lat_nx       = lat_cnt;
    starve_nx    = starve_cnt;
    halt_pend_nx = halt_pend | (bus.haltReq & (state != S_HALTED));
    owner_d_nx   = owner_d;
    err_nx       = err_q;
    wr_nx        = wr_q;
    addr_nx      = addr_q;
    wdata_nx     = wdata_q;
    grant_if     = 1'b0;
    grant_d      = 1'b0;
    capture      = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.dReq && bus.dAddr[0]) begin
          // Unaligned data access: answer with an error, never touch memory.
          state_nx   = S_DONE;
          owner_d_nx = 1'b1;
          err_nx     = 1'b1;
          wr_nx      = 1'b0;
          addr_nx    = '0;
          wdata_nx   = '0;
        end else if (bus.dReq && bus.ifReq && STARVE_ON && (starve_cnt == STARVE_LIM)) begin
          grant_if  = 1'b1;
          starve_nx = '0;
        end else if (bus.dReq) begin
          grant_d = 1'b1;
          if (bus.ifReq) begin
            starve_nx = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
          end else begin
            starve_nx = '0;
          end
        end else if (bus.haltReq || halt_pend) begin
          state_nx = S_HALTED;
        end else if (bus.ifReq) begin
          grant_if  = 1'b1;
          starve_nx = '0;
        end
      end
      S_ISSUE: begin
        lat_nx   = LAT_INIT;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = S_DONE;
        end else begin
          lat_nx = lat_cnt - 4'd1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      S_HALTED: begin
        state_nx = S_HALTED;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Request fields are frozen here so memAddr/memWrData cannot follow late input changes.
    if (grant_if) begin
      state_nx   = S_ISSUE;
      owner_d_nx = 1'b0;
      err_nx     = 1'b0;
      wr_nx      = 1'b0;
      addr_nx    = bus.ifAddr;
      wdata_nx   = '0;
    end
    if (grant_d) begin
      state_nx   = S_ISSUE;
      owner_d_nx = 1'b1;
      err_nx     = 1'b0;
      wr_nx      = bus.dWr;
      addr_nx    = bus.dAddr;
      wdata_nx   = bus.dWr ? bus.dWrData : 16'h0000;
    end
  end

  assign mem_en  = (state == S_ISSUE);
  assign in_done = (state == S_DONE);

  assign bus.memEn     = mem_en;
  assign bus.memWr     = mem_en & wr_q;
  assign bus.memAddr   = mem_en ? addr_q  : 16'h0000;
  assign bus.memWrData = (mem_en && wr_q) ? wdata_q : 16'h0000;

  assign bus.ifDone  = in_done & ~owner_d;
  assign bus.dDone   = in_done & owner_d;
  assign bus.dErr    = in_done & owner_d & err_q;
  assign bus.ifData  = if_data_q;
  assign bus.dRdData = d_rd_data_q;
  assign bus.halted  = (state == S_HALTED);

  assign state_dbg = state;

endmodule
